// File: rtl/micro_rtc_responder.sv
// micro_rtc_responder: real-time-clock peripheral on the KCPSM6 port bus.
//   Holds a BCD time of day (seg/min/hora) that advances once every PRESCALE clocks.
//   Raises a level interrupt on each second (and on an alarm match when built with
//   RTC_ALARM_EN), and serves register reads through a registered in_port.
// Optional feature macro: RTC_ALARM_EN (alarm registers at offsets 5..7).
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   dir[7:0]       port_id from the micro
//   out_port[7:0]  write data from the micro
//   writestrobe    one-cycle write strobe
//   read_strobe    one-cycle read strobe (no side effects)
//   actRTC         chip select from the micro's address decode
//   interrupt_ack  interrupt acknowledge from the micro
//   in_port[7:0]   registered read data (00 on miss or deselect)
//   interrupt      level interrupt request, held until acknowledged
module micro_rtc_responder #(
  parameter logic [7:0]  BASE     = 8'h00,
  parameter int unsigned PRESCALE = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dir,
  input  logic [7:0] out_port,
  input  logic       writestrobe,
  input  logic       read_strobe,
  input  logic       actRTC,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} irq_state_e;

  logic [7:0]    seg_q, min_q, hora_q, ctrl_q;
  logic [7:0]    seg_d, min_d, hora_d;
  logic          tick_flag_q, alarm_flag_q;
  logic [PW-1:0] presc_q;
  logic          tick_pend_q;
  logic [7:0]    offset;
  logic [2:0]    reg_sel;
  logic          hit, wr, time_wr, status_wr;
  logic          tick_raw, tick_apply, alarm_hit, irq_event;
  logic [7:0]    rd_data_c;
  irq_state_e    state_q, state_d;
  logic          unused_read_strobe;

  // Reads are pure mux selections; the strobe carries no information here.
  assign unused_read_strobe = read_strobe;

  // Address decode relative to BASE; the block owns eight consecutive ports.
  assign offset    = dir - BASE;
  assign reg_sel   = offset[2:0];
  assign hit       = (offset[7:3] == 5'd0);
  assign wr        = writestrobe & actRTC & hit;
  assign time_wr   = wr & (reg_sel < 3'd3);
  assign status_wr = wr & (reg_sel == 3'd4);

  // A tick colliding with a time write is pushed one cycle so it acts on the new value.
  assign tick_raw   = ctrl_q[0] & (presc_q == PRESC_MAX);
  assign tick_apply = (tick_raw & ~time_wr) | tick_pend_q;
  assign irq_event  = (tick_apply | alarm_hit) & ctrl_q[1];

  // BCD digit increment; a non-BCD digit is forced to 0 instead of incremented.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] maxv);
    logic [3:0] hi, lo;
    hi = (v[7:4] > 4'd9) ? 4'd0 : v[7:4];
    lo = v[3:0];
    if (v == maxv) begin
      hi = 4'd0;
      lo = 4'd0;
    end else if (lo > 4'd9) begin
      lo = 4'd0;
    end else if (lo == 4'd9) begin
      lo = 4'd0;
      hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Time-of-day values after a tick (before any concurrent register write).
  always_comb begin
    seg_d  = seg_q;
    min_d  = min_q;
    hora_d = hora_q;
    if (tick_apply) begin
      seg_d = bcd_next(seg_q, 8'h59);
      if (seg_q == 8'h59) begin
        min_d = bcd_next(min_q, 8'h59);
        if (min_q == 8'h59) hora_d = bcd_next(hora_q, 8'h23);
      end
    end
  end

  // Prescaler and deferred-tick flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      tick_pend_q <= tick_raw & time_wr;
      if (ctrl_q[0]) presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  // Time, control and tick flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q       <= 8'h00;
      min_q       <= 8'h00;
      hora_q      <= 8'h00;
      ctrl_q      <= 8'h00;
      tick_flag_q <= 1'b0;
    end else begin
      seg_q       <= (wr && reg_sel == 3'd0) ? out_port : seg_d;
      min_q       <= (wr && reg_sel == 3'd1) ? out_port : min_d;
      hora_q      <= (wr && reg_sel == 3'd2) ? out_port : hora_d;
      if (wr && reg_sel == 3'd3) ctrl_q <= out_port;
      // Setting wins over a same-cycle write-1-to-clear.
      tick_flag_q <= tick_apply | (tick_flag_q & ~(status_wr & out_port[0]));
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0] alm_seg_q, alm_min_q, alm_hora_q;

  assign alarm_hit = tick_apply &&
                     ({hora_d, min_d, seg_d} == {alm_hora_q, alm_min_q, alm_seg_q});

  // Alarm compare registers and sticky alarm flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alm_seg_q    <= 8'h00;
      alm_min_q    <= 8'h00;
      alm_hora_q   <= 8'h00;
      alarm_flag_q <= 1'b0;
    end else begin
      if (wr && reg_sel == 3'd5) alm_seg_q  <= out_port;
      if (wr && reg_sel == 3'd6) alm_min_q  <= out_port;
      if (wr && reg_sel == 3'd7) alm_hora_q <= out_port;
      alarm_flag_q <= alarm_hit | (alarm_flag_q & ~(status_wr & out_port[1]));
    end
  end
`else
  assign alarm_hit    = 1'b0;
  assign alarm_flag_q = 1'b0;
`endif

  // Read mux; unimplemented offsets, misses and deselect all read 00.
  always_comb begin
    rd_data_c = 8'h00;
    if (actRTC && hit) begin
      case (reg_sel)
        3'd0:    rd_data_c = seg_q;
        3'd1:    rd_data_c = min_q;
        3'd2:    rd_data_c = hora_q;
        3'd3:    rd_data_c = ctrl_q;
        3'd4:    rd_data_c = {6'b0, alarm_flag_q, tick_flag_q};
`ifdef RTC_ALARM_EN
        3'd5:    rd_data_c = alm_seg_q;
        3'd6:    rd_data_c = alm_min_q;
        3'd7:    rd_data_c = alm_hora_q;
`endif
        default: rd_data_c = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_port <= 8'h00;
    else        in_port <= rd_data_c;
  end

  // Interrupt FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      interrupt <= 1'b0;
    end else begin
      state_q   <= state_d;
      interrupt <= (state_d == S_REQ);
    end
  end

  // A new event in the ack cycle keeps the request asserted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (irq_event) state_d = S_REQ;
      S_REQ:   if (interrupt_ack && !irq_event) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_micro_rtc_responder.sv
// Self-checking bench for micro_rtc_responder (PRESCALE=10, BASE=00).
// The reference model keeps the time of day as decimal seconds-of-day arithmetic.
module tb_micro_rtc_responder;

  localparam int PRESCALE = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dir = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       writestrobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic       actRTC = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_sec, m_min, m_hr, m_presc;
  logic [7:0] m_ctrl;
  logic [7:0] m_al [3];
  bit         m_tf, m_af, m_int, m_pend;

  micro_rtc_responder #(.BASE(8'h00), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset(reset), .dir(dir), .out_port(out_port),
    .writestrobe(writestrobe), .read_strobe(read_strobe), .actRTC(actRTC),
    .interrupt_ack(interrupt_ack), .in_port(in_port), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec2bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int bcd2dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] d);
    case (d)
      8'd0: return dec2bcd(m_sec);
      8'd1: return dec2bcd(m_min);
      8'd2: return dec2bcd(m_hr);
      8'd3: return m_ctrl;
      8'd4: return {6'b0, m_af, m_tf};
`ifdef RTC_ALARM_EN
      8'd5: return m_al[0];
      8'd6: return m_al[1];
      8'd7: return m_al[2];
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_presc = 0;
    m_ctrl = 8'h00; m_al[0] = 8'h00; m_al[1] = 8'h00; m_al[2] = 8'h00;
    m_tf = 0; m_af = 0; m_int = 0; m_pend = 0;
  endtask

  // One bus cycle: drive, clock, advance the model, compare outputs.
  task automatic cyc(input logic [7:0] d, input logic [7:0] wd, input bit ws,
                     input bit act, input bit ack);
    logic [7:0] exp_in;
    bit hit, wr, tick_raw, tw, apply, ahit, ev, irq_en;
    int tod, ns, nm, nh;
    dir = d; out_port = wd; writestrobe = ws; actRTC = act;
    interrupt_ack = ack; read_strobe = !ws;
    @(posedge clk);
    hit      = (d < 8);
    wr       = ws && act && hit;
    exp_in   = (act && hit) ? m_read(d) : 8'h00;
    irq_en   = m_ctrl[1];
    tick_raw = m_ctrl[0] && (m_presc == PRESCALE - 1);
    tw       = wr && (d <= 2);
    apply    = (tick_raw && !tw) || m_pend;
    m_pend   = tick_raw && tw;
    if (m_ctrl[0]) m_presc = (m_presc + 1) % PRESCALE;
    ns = m_sec; nm = m_min; nh = m_hr;
    if (apply) begin
      tod = (m_hr * 3600 + m_min * 60 + m_sec + 1) % 86400;
      nh = tod / 3600; nm = (tod / 60) % 60; ns = tod % 60;
    end
    ahit = 0;
`ifdef RTC_ALARM_EN
    ahit = apply && dec2bcd(ns) == m_al[0] && dec2bcd(nm) == m_al[1] && dec2bcd(nh) == m_al[2];
`endif
    ev    = (apply || ahit) && irq_en;
    m_int = m_int ? (ev || !ack) : ev;
    if (wr && d == 4 && wd[0]) m_tf = 0;
    if (wr && d == 4 && wd[1]) m_af = 0;
    if (apply) m_tf = 1;
    if (ahit)  m_af = 1;
    if (wr) begin
      case (d)
        8'd0: ns = bcd2dec(wd);
        8'd1: nm = bcd2dec(wd);
        8'd2: nh = bcd2dec(wd);
        8'd3: m_ctrl = wd;
`ifdef RTC_ALARM_EN
        8'd5: m_al[0] = wd;
        8'd6: m_al[1] = wd;
        8'd7: m_al[2] = wd;
`endif
        default: ;
      endcase
    end
    m_sec = ns; m_min = nm; m_hr = nh;
    #1;
    check("in_port", in_port, exp_in);
    check("interrupt", {7'b0, interrupt}, {7'b0, m_int});
  endtask

  task automatic wr_reg(input logic [7:0] d, input logic [7:0] wd);
    cyc(d, wd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] d);
    cyc(d, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Idle until the model says the next cycle is a tick cycle (bounded).
  task automatic wait_phase();
    int n = 0;
    while (m_presc != PRESCALE - 1 && n < 4 * PRESCALE) begin
      rd_reg(8'h00);
      n++;
    end
    if (m_presc != PRESCALE - 1) begin
      checks++; errors++;
      $error("FAIL wait_phase timeout observed=%0d expected=%0d", m_presc, PRESCALE - 1);
    end
  endtask

  initial begin
    logic [7:0] d, wd;
    int n;

    // 1: reset held 3 cycles, then reads of 0..4 return 00
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_port", in_port, 8'h00);
    check("rst_interrupt", {7'b0, interrupt}, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_reg(8'(i));
      check("rst_read", in_port, 8'h00);
    end

    // 2: run + irq_en, first tick after 10 clocks, ack, W1C
    wr_reg(8'd3, 8'h03);
    repeat (PRESCALE) rd_reg(8'h00);
    check("t2_int", {7'b0, interrupt}, 8'h01);
    rd_reg(8'h00);
    check("t2_seg", in_port, 8'h01);
    cyc(8'h04, 8'h00, 1'b0, 1'b1, 1'b1);
    check("t2_ack", {7'b0, interrupt}, 8'h00);
    check("t2_flag", in_port, 8'h01);
    wr_reg(8'd4, 8'h01);
    rd_reg(8'd4);
    check("t2_w1c", in_port, 8'h00);

    // 3: rollover 23:59:59 -> 00:00:00
    wr_reg(8'd0, 8'h59);
    wr_reg(8'd1, 8'h59);
    wr_reg(8'd2, 8'h23);
    wait_phase();
    rd_reg(8'h00);
    rd_reg(8'd0); check("t3_seg", in_port, 8'h00);
    rd_reg(8'd1); check("t3_min", in_port, 8'h00);
    rd_reg(8'd2); check("t3_hora", in_port, 8'h00);

    // 4: write in the tick cycle defers the tick by one cycle
    wait_phase();
    wr_reg(8'd0, 8'h09);
    rd_reg(8'd0); check("t4_written", in_port, 8'h09);
    rd_reg(8'd0); check("t4_deferred", in_port, 8'h10);

    // 5: ack in the same cycle as the next tick keeps the request
    wait_phase();
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check("t5_ack_tick", {7'b0, interrupt}, 8'h01);
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check("t5_ack", {7'b0, interrupt}, 8'h00);
    // irq_en cleared while pending: request stays until ack, then no more requests
    wait_phase();
    rd_reg(8'h00);
    wr_reg(8'd3, 8'h01);
    check("t5_pending", {7'b0, interrupt}, 8'h01);
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    wait_phase();
    rd_reg(8'h00);
    check("t5_masked", {7'b0, interrupt}, 8'h00);

    // 6: alarm at 00:00:05 (absent without the macro)
    wr_reg(8'd3, 8'h02);
    cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    wr_reg(8'd4, 8'h03);
    wr_reg(8'd5, 8'h05);
    wr_reg(8'd6, 8'h00);
    wr_reg(8'd7, 8'h00);
    wr_reg(8'd2, 8'h00);
    wr_reg(8'd1, 8'h00);
    wr_reg(8'd0, 8'h04);
    wr_reg(8'd3, 8'h03);
    wait_phase();
    rd_reg(8'h00);
    rd_reg(8'd4);
`ifdef RTC_ALARM_EN
    check("t6_alarm_flag", in_port, 8'h03);
`else
    check("t6_no_alarm", in_port, 8'h01);
`endif
    check("t6_int", {7'b0, interrupt}, 8'h01);
    rd_reg(8'd5);
`ifdef RTC_ALARM_EN
    check("t6_alarm_reg", in_port, 8'h05);
`else
    check("t6_dir5", in_port, 8'h00);
`endif
    wr_reg(8'd3, 8'h00);
    cyc(8'd0, 8'h33, 1'b1, 1'b0, 1'b1);
    rd_reg(8'd0);
    check("t6_deselect", in_port, 8'h05);
    cyc(8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t6_rd_deselect", in_port, 8'h00);

    // Randomised traffic against the model
    wr_reg(8'd3, 8'h03);
    for (int i = 0; i < 600; i++) begin
      n = int'($urandom_range(0, 15));
      d = (n < 10) ? 8'(n) : 8'($urandom);
      case (d)
        8'd0, 8'd1, 8'd5, 8'd6: wd = dec2bcd(int'($urandom_range(0, 59)));
        8'd2, 8'd7:             wd = dec2bcd(int'($urandom_range(0, 23)));
        8'd3:                   wd = 8'($urandom) | 8'(($urandom_range(0, 3) != 0) ? 1 : 0);
        default:                wd = 8'($urandom);
      endcase
      cyc(d, wd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) == 0));
    end

    // Reset mid-operation with a deferred tick pending
    wr_reg(8'd3, 8'h03);
    wait_phase();
    wr_reg(8'd0, 8'h30);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_in_port", in_port, 8'h00);
    check("mid_rst_int", {7'b0, interrupt}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_reg(8'(i));
      check("mid_rst_read", in_port, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
